// File: rtl/apb_mem_slave.sv
//------------------------------------------------------------------------------
// apb_mem_slave : APB word-addressed memory slave, WAIT_STATES access stalls.
// Define APB_MEM_PSLVERR_EN to flag out-of-range accesses on PSLVERR. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module apb_mem_slave #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      WAIT_C  = 4'(WAIT_STATES);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic setup_w;
  logic complete_w;
  logic paddr_ok_w;
  logic addr_ok_w;
  logic mem_we_w;

  assign setup_w    = PSEL & ~PENABLE;
  assign complete_w = (state_q == ACCESS) & PSEL & PENABLE & (cnt_q == 4'd0);
  assign paddr_ok_w = ({1'b0, PADDR} < DEPTH_C);
  assign addr_ok_w  = ({1'b0, addr_q} < DEPTH_C);
  assign mem_we_w   = complete_w & write_q & addr_ok_w & ~PRESET;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    prdata_d  = prdata_q;
    pslverr_d = 1'b0;

    // A setup phase restarts the transfer from either state, dropping any
    // transfer still in its access phase.
    if (setup_w) begin
      state_d = ACCESS;
      cnt_d   = WAIT_C;
      addr_d  = PADDR;
      write_d = PWRITE;
      wdata_d = PWDATA;
      if (!PWRITE) begin
        prdata_d = paddr_ok_w ? mem[PADDR[IDX_W-1:0]] : '0;
      end
    end else if (state_q == ACCESS) begin
      if (!PSEL || (cnt_q == 4'd0)) begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end

    pready_d = (state_d == ACCESS) && (cnt_d == 4'd0);
`ifdef APB_MEM_PSLVERR_EN
    pslverr_d = pready_d && ({1'b0, addr_d} >= DEPTH_C);
`endif
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge PCLK) begin
    if (mem_we_w) begin
      mem[addr_q[IDX_W-1:0]] <= wdata_q;
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_mem_slave.sv
//------------------------------------------------------------------------------
// tb_apb_mem_slave : randomized APB traffic against a word-array reference
// model, responses checked by a scoreboard monitor. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_apb_mem_slave;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 64;
  localparam int WS     = 3;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  always #5 PCLK = ~PCLK;

  apb_mem_slave #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .DEPTH       (DEPTH),
    .WAIT_STATES (WS)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge PCLK) cyc++;

  typedef struct {
    bit          chk_data;
    logic [7:0]  data;
    logic        slverr;
  } exp_t;

  exp_t sb[$];

  // Reference model: plain word array plus knowledge of the last read value.
  logic [7:0] ref_mem   [DEPTH];
  bit         ref_known [DEPTH];
  logic [7:0] last_rd;
  bit         last_known;

  function automatic logic exp_err(int a);
    logic r;
    r = (a >= DEPTH);
`ifndef APB_MEM_PSLVERR_EN
    r = 1'b0;
`endif
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every completing access cycle must match the oldest expectation.
  exp_t mon_e;
  always @(negedge PCLK) begin
    if (!PRESET && PSEL && PENABLE && PREADY) begin
      if (sb.size() == 0) begin
        check("unexpected_completion", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.chk_data) check("prdata", {24'd0, PRDATA}, {24'd0, mon_e.data});
        check("pslverr", {31'd0, PSLVERR}, {31'd0, mon_e.slverr});
      end
    end
  end

  // Full transfer; entered and left just after a rising edge.
  task automatic xfer(input bit wr, input int a, input logic [7:0] d);
    exp_t e;
    int   waits;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = a[7:0];
    PWDATA  = d;
    e.slverr = exp_err(a);
    if (wr) begin
      e.chk_data = last_known;
      e.data     = last_rd;
      if (a < DEPTH) begin
        ref_mem[a]   = d;
        ref_known[a] = 1'b1;
      end
    end else begin
      if (a >= DEPTH) begin
        last_rd    = 8'h00;
        last_known = 1'b1;
      end else begin
        last_rd    = ref_mem[a];
        last_known = ref_known[a];
      end
      e.chk_data = last_known;
      e.data     = last_rd;
    end
    sb.push_back(e);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits   = 0;
    while (!PREADY && waits < 20) begin
      @(posedge PCLK); #1;
      waits++;
    end
    check("wait_states", waits, WS);
    @(posedge PCLK); #1;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
  endtask

  int start_cyc;

  initial begin
    PRESET  = 1'b1;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
    for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;
    last_rd    = 8'h00;
    last_known = 1'b1;

    #2;
    check("reset_pready", {31'd0, PREADY}, 32'd0);
    check("reset_pslverr", {31'd0, PSLVERR}, 32'd0);
    check("reset_prdata", {24'd0, PRDATA}, 32'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;

    xfer(1'b1, 3, 8'hA5);
    xfer(1'b0, 3, 8'h00);

    // Back-to-back fill of the whole array.
    start_cyc = cyc;
    for (int i = 0; i < DEPTH; i++) xfer(1'b1, i, 8'($urandom));
    check("b2b_cycles", cyc - start_cyc, DEPTH * (WS + 2));
    for (int i = 0; i < DEPTH; i++) xfer(1'b0, i, 8'h00);

    // Out-of-range write must not alias onto 70 mod 64.
    xfer(1'b1, 70, 8'h5A);
    xfer(1'b0, 70, 8'h00);
    xfer(1'b0, 6, 8'h00);

    // Abort a write by dropping PSEL during the access phase.
    xfer(1'b1, 5, 8'h11);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'd5; PWDATA = 8'h3C;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    check("abort_pready", {31'd0, PREADY}, 32'd0);
    if (last_known) check("abort_prdata_hold", {24'd0, PRDATA}, {24'd0, last_rd});
    xfer(1'b0, 5, 8'h00);

    // New setup while in access drops the pending write.
    xfer(1'b1, 9, 8'h22);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'd9; PWDATA = 8'hEE;
    @(posedge PCLK); #1;
    xfer(1'b0, 9, 8'h00);

    // Asynchronous reset while the access phase is ready to complete.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'd9; PWDATA = 8'h3C;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    repeat (WS) @(posedge PCLK);
    #3;
    check("pre_reset_pready", {31'd0, PREADY}, 32'd1);
    PRESET = 1'b1;
    #1;
    check("async_rst_pready", {31'd0, PREADY}, 32'd0);
    check("async_rst_prdata", {24'd0, PRDATA}, 32'd0);
    check("async_rst_pslverr", {31'd0, PSLVERR}, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESET     = 1'b0;
    last_rd    = 8'h00;
    last_known = 1'b1;
    xfer(1'b0, 9, 8'h00);

    // Random mix of reads/writes, some out of range, some idle gaps.
    repeat (150) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge PCLK); #1;
      end
      xfer(1'($urandom_range(0, 1)), int'($urandom_range(0, 95)), 8'($urandom));
    end

    repeat (3) @(posedge PCLK);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/apb_mem_slave.md
APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 8, PWDATA/PRDATA width in bits (>=8).
REQ-002 SHALL have parameter ADDR_W, default 8, PADDR width in bits.
REQ-003 SHALL have parameter DEPTH, default 64, number of DATA_W words (<= 2**ADDR_W).
REQ-004 SHALL have parameter WAIT_STATES, default 0, access-phase cycles with PREADY low before completion (0..15).
REQ-005 SHALL have port PCLK, input, 1, sole clock; all state changes on its rising edge.
REQ-006 SHALL have port PRESET, input, 1; reset is asynchronous and active-high.
REQ-007 SHALL have port PSEL, input, 1, slave select.
REQ-008 SHALL have port PENABLE, input, 1, access-phase indicator.
REQ-009 SHALL have port PWRITE, input, 1, 1 = write, 0 = read.
REQ-010 SHALL have port PADDR, input, ADDR_W, word address.
REQ-011 SHALL have port PWDATA, input, DATA_W, write data.
REQ-012 SHALL have port PRDATA, output, DATA_W, registered read data.
REQ-013 SHALL have port PREADY, output, 1, transfer completion.
REQ-014 SHALL have port PSLVERR, output, 1, error response, valid only while PREADY=1.

Function
REQ-015 SHALL implement FSM states IDLE and ACCESS, plus wait counter cnt (4 bits).
REQ-016 IDLE: PSEL=1 and PENABLE=0 -> ACCESS; latch PADDR, PWRITE, PWDATA; cnt <= WAIT_STATES; otherwise remain IDLE.
REQ-017 Read setup edge: PRDATA <= mem[PADDR] if PADDR < DEPTH, else all-zeros.
REQ-018 ACCESS: PREADY = 1 iff cnt==0, decoded from registers with no input path; while cnt!=0, cnt decrements each cycle.
REQ-019 ACCESS, PSEL=1, PENABLE=1, cnt==0 at edge: transfer completes; write commits latched data to mem[latched addr]; next state IDLE.
REQ-020 With WAIT_STATES=0, a transfer SHALL take exactly 2 cycles (setup + access); with N, it SHALL take N+2.
REQ-021 Back-to-back: a setup phase in the cycle after completion SHALL be accepted with no idle cycle lost.
REQ-022 ACCESS, PSEL=0: abort; next state IDLE; no memory write; PRDATA unchanged.
REQ-023 ACCESS, PSEL=1, PENABLE=0: treat as a new setup phase per REQ-016; the previous transfer is dropped.
REQ-024 Address out of range (latched addr >= DEPTH): writes SHALL not modify memory.
REQ-025 PRDATA SHALL hold its last value except on a read setup edge.
REQ-026 Memory contents SHALL not be affected by reset; contents before the first write are undefined.

Reset
REQ-027 PRESET=1 SHALL force state=IDLE, cnt=0, PREADY=0, PSLVERR=0, PRDATA=0 immediately, without waiting for PCLK.
REQ-028 Reset during ACCESS SHALL abort the transfer with no memory write.
REQ-029 The first setup phase SHALL be accepted on the first PCLK edge after PRESET deasserts.

Configuration
REQ-030 Macro APB_MEM_PSLVERR_EN defined: PSLVERR = PREADY & (latched addr >= DEPTH).
REQ-031 Macro APB_MEM_PSLVERR_EN undefined: PSLVERR tied 0; out-of-range behaviour otherwise as REQ-017/REQ-024.

Verification
REQ-032 WAIT_STATES=0: write 0xA5 to addr 3, then read addr 3 -> PREADY high in each access cycle; PRDATA=0xA5; PSLVERR=0.
REQ-033 WAIT_STATES=3: read addr 3 -> PREADY low for 3 access cycles, high on the 4th; transfer spans 5 cycles.
REQ-034 DEPTH=64, macro defined: write addr 70 then read addr 70 -> PSLVERR=1 with PREADY, PRDATA=0x00; addr 6 (70 mod 64) unchanged. Macro undefined: PSLVERR=0.
REQ-035 Back-to-back writes to addrs 0..63 with no idle cycles -> 128 cycles total; readback matches every word.
REQ-036 Drop PSEL mid-ACCESS on a write of 0x3C to addr 5 -> FSM returns to IDLE; mem[5] retains its prior value.
REQ-037 Assert PRESET asynchronously mid-ACCESS -> PREADY and PRDATA=0 before the next edge; no write occurs; the next transfer completes normally.
